// File: rtl/rv32i_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_lsu_ctrl
//
// Load/store unit controller for an RV32I core. It accepts one access request
// from the core, checks its alignment, and runs a single request/acknowledge
// transaction on a word-wide memory bus. Loads are lane-extracted and sign- or
// zero-extended. Bus stalls longer than TIMEOUT cycles finish with a bus fault.
//
// Parameters
//   TIMEOUT          max REQ cycles without bus_ack before faulting (1..255)
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   start            one-cycle request from the core, sampled only in IDLE
//   mem_read         access is a load
//   mem_write        access is a store
//   mem_width        MEM_BYTE / MEM_HALF / MEM_WORD (other codes act as word)
//   mem_unsigned     zero-extend the load result when 1
//   addr             byte address
//   wdata            store data, right-aligned
//   busy             access in flight (REQ or RESP)
//   done             one-cycle completion pulse
//   rdata            extended load result, valid while done=1
//   fault_misaligned misaligned or contradictory access, valid while done=1
//   fault_bus        bus_ack timeout, valid while done=1
//   bus_req          memory request
//   bus_we           memory write strobe
//   bus_addr         word address (low two bits zero)
//   bus_be           byte enables
//   bus_wdata        store data replicated across lanes
//   bus_rdata        memory read data word
//   bus_ack          one-cycle completion from memory
// -----------------------------------------------------------------------------
module rv32i_lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault_misaligned,
  output logic        fault_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Width encodings shared with the core decoder (funct3[1:0] of loads/stores).
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Value the wait counter holds during the last REQ cycle allowed.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        uns_q;
  logic        we_q;
  logic [7:0]  wait_q;
  logic [31:0] rdata_q;
  logic        fault_mis_q;
  logic        fault_bus_q;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic [1:0] width_norm;
  logic       misaligned;
  logic       accept;
  logic       go_bus;
  logic       bad_access;

  assign width_norm = (mem_width == MEM_BYTE || mem_width == MEM_HALF) ? mem_width : MEM_WORD;
  assign misaligned = (width_norm == MEM_HALF && addr[0]) ||
                      (width_norm == MEM_WORD && addr[1:0] != 2'b00);
  assign accept     = start && (state_q == S_IDLE);
  // Exactly one of read/write and aligned: the only case that touches the bus.
  assign go_bus     = accept && (mem_read ^ mem_write) && !misaligned;
  // Read+write together is contradictory and reported like a misalignment.
  assign bad_access = (mem_read && mem_write) || ((mem_read || mem_write) && misaligned);

  logic wait_expired;
  assign wait_expired = (wait_q == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable of a combinational block gets a default first so no
  // path through the case statement leaves it unassigned (which infers a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = go_bus ? S_REQ : S_RESP;
      S_REQ:  if (bus_ack || wait_expired) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction from the live bus word (captured on ack)
  // ---------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;

  always_comb begin
    load_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: load_byte = bus_rdata[7:0];
      2'd1: load_byte = bus_rdata[15:8];
      2'd2: load_byte = bus_rdata[23:16];
      2'd3: load_byte = bus_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (width_q)
      MEM_BYTE: load_val = {{24{~uns_q & load_byte[7]}}, load_byte};
      MEM_HALF: load_val = {{16{~uns_q & load_half[15]}}, load_half};
      default:  load_val = bus_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= MEM_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      rdata_q     <= '0;
      fault_mis_q <= 1'b0;
      fault_bus_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            fault_mis_q <= bad_access;
            fault_bus_q <= 1'b0;
            rdata_q     <= '0;
            wait_q      <= '0;
            if (go_bus) begin
              addr_q  <= addr;
              wdata_q <= wdata;
              width_q <= width_norm;
              uns_q   <= mem_unsigned;
              we_q    <= mem_write;
            end
          end
        end
        S_REQ: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (bus_ack) begin
            rdata_q <= we_q ? 32'h0 : load_val;
          end else begin
            wait_q <= wait_q + 8'd1;
            if (wait_expired) fault_bus_q <= 1'b1;
          end
        end
        S_RESP: begin
          rdata_q     <= '0;
          fault_mis_q <= 1'b0;
          fault_bus_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: bus fields are forced to zero outside REQ, results outside RESP.
  // ---------------------------------------------------------------------------
  logic [3:0]  be_raw;
  logic [31:0] wdata_rep;

  always_comb begin
    case (width_q)
      MEM_BYTE: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      MEM_HALF: begin
        be_raw    = 4'b0011 << addr_q[1:0];
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  assign bus_req          = (state_q == S_REQ);
  assign bus_we           = bus_req & we_q;
  assign bus_addr         = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be           = bus_req ? be_raw : 4'b0000;
  assign bus_wdata        = bus_req ? wdata_rep : 32'h0;

  assign done             = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);
  assign rdata            = done ? rdata_q : 32'h0;
  assign fault_misaligned = done & fault_mis_q;
  assign fault_bus        = done & fault_bus_q;

endmodule

// File: tb/tb_rv32i_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32i_lsu_ctrl
//
// Self-checking bench for rv32i_lsu_ctrl (instantiated with TIMEOUT=4).
// A driver task runs one access and records what the DUT did cycle by cycle;
// an access-level reference model predicts the same record from the access
// rules (lane arithmetic, alignment, latency, timeout).
// -----------------------------------------------------------------------------
module tb_rv32i_lsu_ctrl;

  localparam int TMO = 4;

  localparam logic [1:0] W_B = 2'b00;
  localparam logic [1:0] W_H = 2'b01;
  localparam logic [1:0] W_W = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_width;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault_misaligned;
  logic        fault_bus;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_checks = 0;
  int n_pass   = 0;

  rv32i_lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_width        (mem_width),
    .mem_unsigned     (mem_unsigned),
    .addr             (addr),
    .wdata            (wdata),
    .busy             (busy),
    .done             (done),
    .rdata            (rdata),
    .fault_misaligned (fault_misaligned),
    .fault_bus        (fault_bus),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_be           (bus_be),
    .bus_wdata        (bus_wdata),
    .bus_rdata        (bus_rdata),
    .bus_ack          (bus_ack)
  );

  always #5 clk = ~clk;

  // Cycle k=1 is the cycle right after the edge that samples start.
  typedef struct packed {
    int          req_cycles;
    int          done_cycle;
    int          busy_cycles;
    logic [31:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata;
    logic        b_we;
    logic        unstable;
    logic        idle_bus_dirty;
    logic [31:0] rdata;
    logic        f_mis;
    logic        f_bus;
    logic        done_after;
    logic        busy_after;
  } obs_t;

  // Reference model: what one access should look like at the pins.
  function automatic obs_t model(input logic rd, input logic wr, input logic [1:0] w,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int dly);
    obs_t        e;
    int          sz;
    int          off;
    logic [31:0] v;
    e   = '0;
    sz  = (w == W_B) ? 1 : (w == W_H) ? 2 : 4;
    off = int'(a[1:0]);
    if (!rd && !wr) begin
      e.done_cycle  = 1;
      e.busy_cycles = 1;
      return e;
    end
    if ((rd && wr) || (off % sz != 0)) begin
      e.done_cycle  = 1;
      e.busy_cycles = 1;
      e.f_mis       = 1'b1;
      return e;
    end
    e.req_cycles  = (dly < TMO) ? dly + 1 : TMO;
    e.done_cycle  = e.req_cycles + 1;
    e.busy_cycles = e.done_cycle;
    e.b_addr      = a - 32'(off);
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) e.b_be[i] = 1'b1;
      e.b_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    e.b_we = wr;
    if (dly >= TMO) begin
      e.f_bus = 1'b1;
    end else if (rd) begin
      if (sz == 4) begin
        e.rdata = rdw;
      end else begin
        v = rdw >> (8 * off);
        v = v % (32'd1 << (8 * sz));
        if (!uns && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Runs one access; ack is given on REQ cycle dly+1 (never if dly >= TMO).
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] w,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdw, input int dly, output obs_t o);
    o = '0;
    @(negedge clk);
    start = 1'b1; mem_read = rd; mem_write = wr; mem_width = w;
    mem_unsigned = uns; addr = a; wdata = wd; bus_ack = 1'b0;
    @(negedge clk);
    // Scramble the request inputs: the DUT must work from its latched copy.
    start = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    mem_width = 2'($urandom); mem_unsigned = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 300; k++) begin
      if (busy) o.busy_cycles++;
      if (bus_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.b_addr = bus_addr; o.b_be = bus_be; o.b_wdata = bus_wdata; o.b_we = bus_we;
        end else if ({bus_addr, bus_be, bus_wdata, bus_we} !== {o.b_addr, o.b_be, o.b_wdata, o.b_we}) begin
          o.unstable = 1'b1;
        end
        bus_ack   = (o.req_cycles == dly + 1);
        bus_rdata = bus_ack ? rdw : $urandom;
      end else begin
        if ((|{bus_addr, bus_be, bus_wdata, bus_we}) !== 1'b0) o.idle_bus_dirty = 1'b1;
        bus_ack   = 1'($urandom);
        bus_rdata = $urandom;
      end
      if (done) begin
        o.done_cycle = k;
        o.rdata      = rdata;
        o.f_mis      = fault_misaligned;
        o.f_bus      = fault_bus;
        // A valid-looking start during RESP must be ignored.
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_width = W_B;
        @(negedge clk);
        start = 1'b0; bus_ack = 1'b0;
        o.done_after = done;
        o.busy_after = busy;
        if ((|{bus_req, bus_addr, bus_be, bus_wdata, bus_we}) !== 1'b0) o.idle_bus_dirty = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, bus_req, fault_misaligned, fault_bus} !== 5'b0) begin
      $display("FAIL reset_ctrl: got busy/done/req/fm/fb=%b required 00000",
               {busy, done, bus_req, fault_misaligned, fault_bus});
    end else n_pass++;
    n_checks++;
    if ({rdata, bus_addr, bus_be, bus_wdata, bus_we} !== '0) begin
      $display("FAIL reset_data: got rdata=%h addr=%h be=%b wdata=%h we=%b required all zero",
               rdata, bus_addr, bus_be, bus_wdata, bus_we);
    end else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_lb_signed();
    obs_t o;
    do_access(1, 0, W_B, 0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, o);
    n_checks++;
    if (o.b_addr !== 32'h1000) $display("FAIL lb_addr: got %h required 00001000", o.b_addr);
    else n_pass++;
    n_checks++;
    if (o.b_be !== 4'b1000) $display("FAIL lb_be: got %b required 1000", o.b_be);
    else n_pass++;
    n_checks++;
    if (o.done_cycle !== 2) $display("FAIL lb_latency: got done at N+%0d required N+2", o.done_cycle);
    else n_pass++;
    n_checks++;
    if (o.rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h required ffffff80", o.rdata);
    else n_pass++;
  endtask

  task automatic test_lhu_delayed();
    obs_t o;
    do_access(1, 0, W_H, 1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3, o);
    n_checks++;
    if (o.b_be !== 4'b1100) $display("FAIL lhu_be: got %b required 1100", o.b_be);
    else n_pass++;
    n_checks++;
    if (o.busy_cycles !== 5) $display("FAIL lhu_busy: got %0d cycles required 5", o.busy_cycles);
    else n_pass++;
    n_checks++;
    if (o.rdata !== 32'h0000_BEEF) $display("FAIL lhu_rdata: got %h required 0000beef", o.rdata);
    else n_pass++;
    n_checks++;
    if (o.unstable !== 1'b0) $display("FAIL lhu_stable: got unstable=%b required 0", o.unstable);
    else n_pass++;
  endtask

  task automatic test_sb();
    obs_t o;
    do_access(0, 1, W_B, 0, 32'h0000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 0, o);
    n_checks++;
    if ({o.b_we, o.b_be} !== 5'b1_0010) $display("FAIL sb_we_be: got we=%b be=%b required we=1 be=0010", o.b_we, o.b_be);
    else n_pass++;
    n_checks++;
    if (o.b_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h required a5a5a5a5", o.b_wdata);
    else n_pass++;
    n_checks++;
    if ({o.done_cycle, o.rdata} !== {32'd2, 32'h0}) $display("FAIL sb_done: got done N+%0d rdata=%h required N+2 rdata=0", o.done_cycle, o.rdata);
    else n_pass++;
  endtask

  task automatic test_faults_and_noop();
    obs_t o;
    do_access(1, 0, W_W, 0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, o);
    n_checks++;
    if ({o.req_cycles, o.done_cycle, o.f_mis, o.f_bus} !== {32'd0, 32'd1, 2'b10})
      $display("FAIL lw_misaligned: got req=%0d done=N+%0d fm=%b fb=%b required req=0 done=N+1 fm=1 fb=0",
               o.req_cycles, o.done_cycle, o.f_mis, o.f_bus);
    else n_pass++;
    do_access(0, 0, W_W, 0, 32'h0000_0007, 32'h0, 32'h1111_1111, 0, o);
    n_checks++;
    if ({o.req_cycles, o.done_cycle, o.f_mis, o.f_bus, o.rdata} !== {32'd0, 32'd1, 2'b00, 32'h0})
      $display("FAIL noop: got req=%0d done=N+%0d fm=%b fb=%b rdata=%h required 0/1/0/0/0",
               o.req_cycles, o.done_cycle, o.f_mis, o.f_bus, o.rdata);
    else n_pass++;
    do_access(1, 1, W_B, 0, 32'h0000_0010, 32'h0, 32'h1111_1111, 0, o);
    n_checks++;
    if ({o.req_cycles, o.done_cycle, o.f_mis} !== {32'd0, 32'd1, 1'b1})
      $display("FAIL rd_and_wr: got req=%0d done=N+%0d fm=%b required req=0 done=N+1 fm=1",
               o.req_cycles, o.done_cycle, o.f_mis);
    else n_pass++;
    // Width code 3 behaves as a word access.
    do_access(1, 0, 2'b11, 0, 32'h0000_0022, 32'h0, 32'h1111_1111, 0, o);
    n_checks++;
    if (o.f_mis !== 1'b1) $display("FAIL width3_misaligned: got fm=%b required 1", o.f_mis);
    else n_pass++;
    do_access(1, 0, 2'b11, 1, 32'h0000_0028, 32'h0, 32'h8765_4321, 0, o);
    n_checks++;
    if ({o.b_be, o.rdata} !== {4'b1111, 32'h8765_4321})
      $display("FAIL width3_word: got be=%b rdata=%h required be=1111 rdata=87654321", o.b_be, o.rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1, 0, W_W, 0, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 99, o);
    n_checks++;
    if ({o.req_cycles, o.done_cycle, o.f_bus, o.f_mis, o.rdata} !== {32'(TMO), 32'(TMO + 1), 2'b10, 32'h0})
      $display("FAIL timeout: got req=%0d done=N+%0d fb=%b fm=%b rdata=%h required req=%0d done=N+%0d fb=1 fm=0 rdata=0",
               o.req_cycles, o.done_cycle, o.f_bus, o.f_mis, o.rdata, TMO, TMO + 1);
    else n_pass++;
    do_access(1, 0, W_W, 0, 32'h0000_0104, 32'h0, 32'h5555_AAAA, TMO - 1, o);
    n_checks++;
    if ({o.req_cycles, o.f_bus, o.rdata} !== {32'(TMO), 1'b0, 32'h5555_AAAA})
      $display("FAIL ack_at_limit: got req=%0d fb=%b rdata=%h required req=%0d fb=0 rdata=5555aaaa",
               o.req_cycles, o.f_bus, o.rdata, TMO);
    else n_pass++;
  endtask

  task automatic test_reset_mid_req();
    obs_t o;
    @(negedge clk);
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_width = W_W; addr = 32'h40; bus_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (bus_req !== 1'b1) $display("FAIL midreq_req1: got bus_req=%b required 1", bus_req);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if ({busy, done, bus_req, fault_misaligned, fault_bus, rdata, bus_addr, bus_be, bus_wdata, bus_we} !== '0)
      $display("FAIL midreq_after_rst: got busy=%b done=%b req=%b rdata=%h addr=%h be=%b required all zero",
               busy, done, bus_req, rdata, bus_addr, bus_be);
    else n_pass++;
    @(negedge clk);
    bus_ack = 1'b0;
    n_checks++;
    if ({busy, done, bus_req, rdata} !== '0)
      $display("FAIL late_ack: got busy=%b done=%b req=%b rdata=%h required all zero", busy, done, bus_req, rdata);
    else n_pass++;
    // The wait counter must start from zero again after the reset.
    do_access(1, 0, W_W, 0, 32'h0000_0200, 32'h0, 32'h0, 99, o);
    n_checks++;
    if ({o.req_cycles, o.f_bus} !== {32'(TMO), 1'b1})
      $display("FAIL post_rst_timeout: got req=%0d fb=%b required req=%0d fb=1", o.req_cycles, o.f_bus, TMO);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t        o;
    obs_t        e;
    logic        rd;
    logic        wr;
    logic [1:0]  w;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          dly;
    int          sel;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      begin rd = 1'b0; wr = 1'b0; end
      else if (sel == 1) begin rd = 1'b1; wr = 1'b1; end
      else begin rd = 1'($urandom); wr = ~rd; end
      w   = 2'($urandom);
      uns = 1'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd  = $urandom;
      rdw = $urandom;
      dly = int'($urandom_range(0, 5));
      do_access(rd, wr, w, uns, a, wd, rdw, dly, o);
      e = model(rd, wr, w, uns, a, wd, rdw, dly);
      n_checks++;
      if (o !== e)
        $display("FAIL random[%0d] rd=%b wr=%b w=%0d uns=%b a=%h dly=%0d: got %h required %h",
                 n, rd, wr, w, uns, a, dly, o, e);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_width = W_B;
    mem_unsigned = 1'b0; addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    test_reset();
    test_lb_signed();
    test_lhu_delayed();
    test_sb();
    test_faults_and_noop();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
